chip8_mem_ctrl: RTL

- Parametrised, synchronous successor to the CHIP-8 byte memory, with a 4 KB single-port array.
- After reset it loads the standard hex font itself and then serves three request types: byte read, byte write with interpreter-area write protection, and 16-bit opcode fetch.
- A small FSM serialises all accesses. Sits between the CPU core/loader and the memory array.

---
 rtl/chip8_mem_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/chip8_mem_ctrl.sv
// CHIP-8 4 KB byte memory controller: self-loads the hex font after reset, then
// serves byte reads, protected byte writes and two-cycle big-endian opcode fetches.
module chip8_mem_ctrl #(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] PROT_TOP  = 12'h200,
  parameter logic [ADDR_W-1:0] FONT_BASE = 12'h050
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                o_busy,
  input  logic                i_rd_en,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic                o_rd_valid,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic                i_load_mode,
  output logic                o_wr_err,
  input  logic                i_fetch_req,
  input  logic [ADDR_W-1:0]   i_fetch_addr,
  output logic [2*DATA_W-1:0] o_fetch_op,
  output logic                o_fetch_valid
);

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_FETCH2 = 2'd2} state_t;

  localparam logic [6:0]      FONT_LAST = 7'd79;
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  state_t            r_state;
  logic [6:0]        r_font_cnt;
  logic [DATA_W-1:0] r_hi;
  logic [ADDR_W-1:0] r_lo_addr;

  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_font_addr;
  logic [ADDR_W-1:0] w_fetch_next;

  function automatic logic [DATA_W-1:0] font_byte(input logic [6:0] k);
    logic [39:0] row;
    logic [6:0]  digit;
    logic [6:0]  pos;
    logic [7:0]  b;
    digit = k / 7'd5;
    pos   = k - digit * 7'd5;
    case (digit[3:0])
      4'h0:    row = 40'hF0_90_90_90_F0;
      4'h1:    row = 40'h20_60_20_20_70;
      4'h2:    row = 40'hF0_10_F0_80_F0;
      4'h3:    row = 40'hF0_10_F0_10_F0;
      4'h4:    row = 40'h90_90_F0_10_10;
      4'h5:    row = 40'hF0_80_F0_10_F0;
      4'h6:    row = 40'hF0_80_F0_90_F0;
      4'h7:    row = 40'hF0_10_20_40_40;
      4'h8:    row = 40'hF0_90_F0_90_F0;
      4'h9:    row = 40'hF0_90_F0_10_F0;
      4'hA:    row = 40'hF0_90_F0_90_90;
      4'hB:    row = 40'hE0_90_E0_90_E0;
      4'hC:    row = 40'hF0_80_80_80_F0;
      4'hD:    row = 40'hE0_90_90_90_E0;
      4'hE:    row = 40'hF0_80_F0_80_F0;
      4'hF:    row = 40'hF0_80_F0_80_80;
      default: row = 40'h0;
    endcase
    case (pos[2:0])
      3'd0:    b = row[39:32];
      3'd1:    b = row[31:24];
      3'd2:    b = row[23:16];
      3'd3:    b = row[15:8];
      default: b = row[7:0];
    endcase
    return DATA_W'(b);
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  function automatic logic [DATA_W-1:0] rd_byte(input logic [ADDR_W-1:0] a);
    if (in_range(a)) begin
      return r_mem[a];
    end else begin
      return '0;
    end
  endfunction

  // Request decode: write legality, font target address and wrapped fetch low address.
  always_comb begin
    w_wr_ok      = 1'b0;
    w_font_addr  = FONT_BASE + ADDR_W'(r_font_cnt);
    w_fetch_next = i_fetch_addr + ADDR_W'(1);
    if ((r_state == ST_IDLE) && i_wr_en && in_range(i_wr_addr) &&
        ((i_wr_addr >= PROT_TOP) || i_load_mode)) begin
      w_wr_ok = 1'b1;
    end else begin
      w_wr_ok = 1'b0;
    end
    if ({1'b0, i_fetch_addr} == (DEPTH_C - (ADDR_W+1)'(1))) begin
      w_fetch_next = '0;
    end else begin
      w_fetch_next = i_fetch_addr + ADDR_W'(1);
    end
  end

  // Array write port; deliberately unreset so program bytes survive a reset.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == ST_INIT)) begin
      r_mem[w_font_addr] <= font_byte(r_font_cnt);
    end else if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Access-serialising FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_font_cnt    <= 7'd0;
      r_hi          <= '0;
      r_lo_addr     <= '0;
      o_busy        <= 1'b1;
      o_rd_data     <= '0;
      o_rd_valid    <= 1'b0;
      o_wr_err      <= 1'b0;
      o_fetch_op    <= '0;
      o_fetch_valid <= 1'b0;
    end else begin
      o_rd_valid    <= 1'b0;
      o_wr_err      <= 1'b0;
      o_fetch_valid <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (r_font_cnt == FONT_LAST) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_font_cnt <= r_font_cnt + 7'd1;
          end
        end
        ST_IDLE: begin
          // Fixed priority; losers are dropped, not queued.
          if (i_wr_en) begin
            o_wr_err <= ~w_wr_ok;
          end else if (i_fetch_req) begin
            r_hi      <= rd_byte(i_fetch_addr);
            r_lo_addr <= w_fetch_next;
            r_state   <= ST_FETCH2;
            o_busy    <= 1'b1;
          end else if (i_rd_en) begin
            o_rd_data  <= rd_byte(i_rd_addr);
            o_rd_valid <= 1'b1;
          end
        end
        ST_FETCH2: begin
          o_fetch_op    <= {r_hi, rd_byte(r_lo_addr)};
          o_fetch_valid <= 1'b1;
          r_state       <= ST_IDLE;
          o_busy        <= 1'b0;
        end
        default: begin
          r_state    <= ST_INIT;
          r_font_cnt <= 7'd0;
          o_busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule
